// File: rtl/control_sequencer_if.sv
// Instruction-source / datapath-control bundle for control_sequencer.
// The master side issues micro-instructions and observes the control lines.
// The slave side is the sequencer itself.
interface control_sequencer_if #(
  parameter int DATA_WIDTH = 32
);
  logic                  start;
  logic [1:0]            opcode;
  logic [DATA_WIDTH-1:0] imm;
  logic                  busy;
  logic                  done;
  logic                  RAin;
  logic                  RBin;
  logic                  RZin;
  logic                  RAout;
  logic                  RBout;
  logic                  RZout;
  logic [DATA_WIDTH-1:0] AddImmediate;
  logic [DATA_WIDTH-1:0] RegisterAImmediate;

  modport master (
    output start, opcode, imm,
    input  busy, done, RAin, RBin, RZin, RAout, RBout, RZout,
    input  AddImmediate, RegisterAImmediate
  );

  modport slave (
    input  start, opcode, imm,
    output busy, done, RAin, RBin, RZin, RAout, RBout, RZout,
    output AddImmediate, RegisterAImmediate
  );
endinterface

// File: rtl/control_sequencer.sv
// Hardwired control sequencer: accepts one micro-instruction per start
// handshake and walks IDLE -> T0 -> [T1] -> DONE, driving registered
// (Moore) register-load, bus-drive and immediate lines for the datapath.
// Each control step is held for HOLD_CYCLES clocks.
module control_sequencer #(
  parameter int DATA_WIDTH  = 32,
  parameter int HOLD_CYCLES = 1
) (
  input  logic               clock,
  input  logic               clear,
  control_sequencer_if.slave bus
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_T0   = 2'd1,
    S_T1   = 2'd2,
    S_DONE = 2'd3
  } state_t;

  localparam logic [1:0] OP_LDIA  = 2'b00;
  localparam logic [1:0] OP_ADDIB = 2'b01;
  localparam logic [1:0] OP_MVBZ  = 2'b10;
  localparam logic [1:0] OP_ADDIA = 2'b11;

  localparam int              CNT_W    = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(HOLD_CYCLES - 1);

  state_t                r_state;
  state_t                w_state_nxt;
  logic [CNT_W-1:0]      r_cnt;
  logic [CNT_W-1:0]      w_cnt_nxt;
  logic [1:0]            r_op;
  logic [DATA_WIDTH-1:0] r_imm;

  logic                  w_accept;
  logic [1:0]            w_op;
  logic [DATA_WIDTH-1:0] w_imm;
  logic                  w_step_end;
  logic                  w_two_step;

  logic                  r_busy, r_done;
  logic                  r_ra_in, r_rb_in, r_rz_in;
  logic                  r_ra_out, r_rb_out, r_rz_out;
  logic [DATA_WIDTH-1:0] r_add_imm, r_ra_imm;

  logic                  w_busy, w_done;
  logic                  w_ra_in, w_rb_in, w_rz_in;
  logic                  w_ra_out, w_rb_out, w_rz_out;
  logic [DATA_WIDTH-1:0] w_add_imm, w_ra_imm;

  // A start is only honoured while idle; the incoming opcode/imm feed the
  // T0 outputs directly on the accepting edge, the latched copy afterwards.
  assign w_accept   = (r_state == S_IDLE) && bus.start;
  assign w_op       = w_accept ? bus.opcode : r_op;
  assign w_imm      = w_accept ? bus.imm    : r_imm;
  assign w_step_end = (r_cnt == CNT_LAST);
  assign w_two_step = w_op[0];

  // Latch the micro-instruction on acceptance; never touched while busy.
  always_ff @(posedge clock) begin
    if (w_accept) begin
      r_op  <= bus.opcode;
      r_imm <= bus.imm;
    end
  end

  // State, hold counter and registered control outputs.
  always_ff @(posedge clock or posedge clear) begin
    if (clear) begin
      r_state   <= S_IDLE;
      r_cnt     <= '0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_ra_in   <= 1'b0;
      r_rb_in   <= 1'b0;
      r_rz_in   <= 1'b0;
      r_ra_out  <= 1'b0;
      r_rb_out  <= 1'b0;
      r_rz_out  <= 1'b0;
      r_add_imm <= '0;
      r_ra_imm  <= '0;
    end else begin
      r_state   <= w_state_nxt;
      r_cnt     <= w_cnt_nxt;
      r_busy    <= w_busy;
      r_done    <= w_done;
      r_ra_in   <= w_ra_in;
      r_rb_in   <= w_rb_in;
      r_rz_in   <= w_rz_in;
      r_ra_out  <= w_ra_out;
      r_rb_out  <= w_rb_out;
      r_rz_out  <= w_rz_out;
      r_add_imm <= w_add_imm;
      r_ra_imm  <= w_ra_imm;
    end
  end

  // Next-state and hold-counter sequencing; counter restarts on every step entry.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    unique case (r_state)
      S_IDLE: begin
        w_cnt_nxt = '0;
        if (w_accept) begin
          w_state_nxt = S_T0;
        end
      end
      S_T0: begin
        if (w_step_end) begin
          w_state_nxt = w_two_step ? S_T1 : S_DONE;
          w_cnt_nxt   = '0;
        end else begin
          w_cnt_nxt = r_cnt + 1'b1;
        end
      end
      S_T1: begin
        if (w_step_end) begin
          w_state_nxt = S_DONE;
          w_cnt_nxt   = '0;
        end else begin
          w_cnt_nxt = r_cnt + 1'b1;
        end
      end
      S_DONE: begin
        w_state_nxt = S_IDLE;
        w_cnt_nxt   = '0;
      end
      default: begin
        w_state_nxt = S_IDLE;
        w_cnt_nxt   = '0;
      end
    endcase
  end

  // Decode the control lines for the state being entered, so they are registered.
  always_comb begin
    w_busy    = (w_state_nxt != S_IDLE);
    w_done    = (w_state_nxt == S_DONE);
    w_ra_in   = 1'b0;
    w_rb_in   = 1'b0;
    w_rz_in   = 1'b0;
    w_ra_out  = 1'b0;
    w_rb_out  = 1'b0;
    w_rz_out  = 1'b0;
    w_add_imm = '0;
    w_ra_imm  = '0;
    if (w_state_nxt == S_T0) begin
      unique case (w_op)
        OP_LDIA: begin
          w_ra_imm = w_imm;
          w_ra_in  = 1'b1;
        end
        OP_ADDIB: begin
          w_ra_out  = 1'b1;
          w_add_imm = w_imm;
          w_rz_in   = 1'b1;
        end
        OP_MVBZ: begin
          w_rz_out = 1'b1;
          w_rb_in  = 1'b1;
        end
        OP_ADDIA: begin
          w_rb_out  = 1'b1;
          w_add_imm = w_imm;
          w_rz_in   = 1'b1;
        end
        default: ;
      endcase
    end else if (w_state_nxt == S_T1) begin
      // Only the two add ops reach T1: move Z back into the destination.
      w_rz_out = 1'b1;
      if (w_op == OP_ADDIB) begin
        w_rb_in = 1'b1;
      end else begin
        w_ra_in = 1'b1;
      end
    end
  end

  assign bus.busy               = r_busy;
  assign bus.done               = r_done;
  assign bus.RAin               = r_ra_in;
  assign bus.RBin               = r_rb_in;
  assign bus.RZin               = r_rz_in;
  assign bus.RAout              = r_ra_out;
  assign bus.RBout              = r_rb_out;
  assign bus.RZout              = r_rz_out;
  assign bus.AddImmediate       = r_add_imm;
  assign bus.RegisterAImmediate = r_ra_imm;

endmodule

// File: tb/tb_control_sequencer.sv
// Directed bench for control_sequencer: one HOLD_CYCLES=1 instance with a
// small A/B/Z datapath model attached, and one HOLD_CYCLES=3 instance.
module tb_control_sequencer;

  logic clk;
  logic clr;
  int   n_checks;
  int   n_err;

  control_sequencer_if #(.DATA_WIDTH(32)) if1 ();
  control_sequencer_if #(.DATA_WIDTH(32)) if3 ();

  control_sequencer #(.DATA_WIDTH(32), .HOLD_CYCLES(1)) u1 (
    .clock (clk),
    .clear (clr),
    .bus   (if1)
  );

  control_sequencer #(.DATA_WIDTH(32), .HOLD_CYCLES(3)) u3 (
    .clock (clk),
    .clear (clr),
    .bus   (if3)
  );

  // Control vector order: busy, done, RAin, RBin, RZin, RAout, RBout, RZout
  logic [7:0] ctl1, ctl3;
  assign ctl1 = {if1.busy, if1.done, if1.RAin, if1.RBin, if1.RZin, if1.RAout, if1.RBout, if1.RZout};
  assign ctl3 = {if3.busy, if3.done, if3.RAin, if3.RBin, if3.RZin, if3.RAout, if3.RBout, if3.RZout};

  localparam logic [7:0] C_IDLE    = 8'b0000_0000;
  localparam logic [7:0] C_DONE    = 8'b1100_0000;
  localparam logic [7:0] C_LDIA0   = 8'b1010_0000;
  localparam logic [7:0] C_ADDIB0  = 8'b1000_1100;
  localparam logic [7:0] C_ADDIB1  = 8'b1001_0001;
  localparam logic [7:0] C_ADDIA0  = 8'b1000_1010;
  localparam logic [7:0] C_ADDIA1  = 8'b1010_0001;

  // Clock: rising edges at 10, 20, 30 ...
  initial clk = 1'b1;
  always #5 clk = ~clk;

  // Datapath model driven by instance u1.
  logic [31:0] dA = 32'd0;
  logic [31:0] dB = 32'd0;
  logic [31:0] dZ = 32'd0;
  always @(posedge clk) begin
    logic [31:0] busv;
    logic        drv;
    drv  = if1.RAout | if1.RBout | if1.RZout;
    busv = if1.RAout ? dA : if1.RBout ? dB : if1.RZout ? dZ : 32'd0;
    if (if1.RAin) dA <= drv ? busv : if1.RegisterAImmediate;
    if (if1.RBin) dB <= busv;
    if (if1.RZin) dZ <= busv + if1.AddImmediate;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk1(input string tag, input logic [7:0] ec, input logic [31:0] eadd, input logic [31:0] era);
    chk({tag, ".ctl"}, {24'd0, ctl1}, {24'd0, ec});
    chk({tag, ".add"}, if1.AddImmediate, eadd);
    chk({tag, ".raimm"}, if1.RegisterAImmediate, era);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  int accepted;
  int dones;
  int guard;

  initial begin
    n_checks = 0;
    n_err    = 0;
    accepted = 0;
    dones    = 0;
    clr = 1'b1;
    if1.start = 1'b0; if1.opcode = 2'b00; if1.imm = 32'd0;
    if3.start = 1'b0; if3.opcode = 2'b00; if3.imm = 32'd0;

    // Reset state while clear is held
    #12;
    chk1("reset", C_IDLE, 32'd0, 32'd0);
    chk("reset3.ctl", {24'd0, ctl3}, 32'd0);
    #3;
    clr = 1'b0;

    // Test 1: LDIA imm=5
    if1.start = 1'b1; if1.opcode = 2'b00; if1.imm = 32'd5;
    tick();
    chk1("t1.T0", C_LDIA0, 32'd0, 32'd5);
    if1.start = 1'b0;
    tick();
    chk1("t1.DONE", C_DONE, 32'd0, 32'd0);
    chk("t1.A", dA, 32'd5);
    tick();
    chk1("t1.IDLE", C_IDLE, 32'd0, 32'd0);

    // Test 2: ADDIB imm=5
    if1.start = 1'b1; if1.opcode = 2'b01; if1.imm = 32'd5;
    tick();
    chk1("t2.T0", C_ADDIB0, 32'd5, 32'd0);
    if1.start = 1'b0;
    tick();
    chk1("t2.T1", C_ADDIB1, 32'd0, 32'd0);
    chk("t2.Z", dZ, 32'd10);
    tick();
    chk1("t2.DONE", C_DONE, 32'd0, 32'd0);
    chk("t2.B", dB, 32'd10);
    tick();
    chk1("t2.IDLE", C_IDLE, 32'd0, 32'd0);

    // Test 3: ADDIB accepted, then LDIA start held through T0/T1/DONE
    if1.start = 1'b1; if1.opcode = 2'b01; if1.imm = 32'd5;
    tick();
    chk1("t3.T0", C_ADDIB0, 32'd5, 32'd0);
    if1.opcode = 2'b00; if1.imm = 32'd9;
    tick();
    chk1("t3.T1", C_ADDIB1, 32'd0, 32'd0);
    tick();
    chk1("t3.DONE", C_DONE, 32'd0, 32'd0);
    chk("t3.B", dB, 32'd10);
    tick();
    chk1("t3.IDLE", C_IDLE, 32'd0, 32'd0);
    if1.start = 1'b0;
    tick();
    chk1("t3.stayIDLE", C_IDLE, 32'd0, 32'd0);

    // Test 4: clear mid-T1 of ADDIA, then LDIA imm=7
    if1.start = 1'b1; if1.opcode = 2'b11; if1.imm = 32'd3;
    tick();
    chk1("t4.T0", C_ADDIA0, 32'd3, 32'd0);
    if1.start = 1'b0;
    tick();
    chk1("t4.T1", C_ADDIA1, 32'd0, 32'd0);
    chk("t4.Z", dZ, 32'd13);
    clr = 1'b1;
    #1;
    chk1("t4.clear", C_IDLE, 32'd0, 32'd0);
    #2;
    clr = 1'b0;
    tick();
    chk1("t4.nodone", C_IDLE, 32'd0, 32'd0);
    chk("t4.Akept", dA, 32'd5);
    if1.start = 1'b1; if1.opcode = 2'b00; if1.imm = 32'd7;
    tick();
    chk1("t4.T0b", C_LDIA0, 32'd0, 32'd7);
    if1.start = 1'b0;
    tick();
    chk1("t4.DONE", C_DONE, 32'd0, 32'd0);
    chk("t4.A", dA, 32'd7);
    tick();
    chk1("t4.IDLE", C_IDLE, 32'd0, 32'd0);

    // Test 5: HOLD_CYCLES=3, ADDIA imm=2
    if3.start = 1'b1; if3.opcode = 2'b11; if3.imm = 32'd2;
    for (int c = 1; c <= 8; c++) begin
      logic [7:0]  ec;
      logic [31:0] ea;
      tick();
      if3.start = 1'b0;
      if (c <= 3) begin
        ec = C_ADDIA0; ea = 32'd2;
      end else if (c <= 6) begin
        ec = C_ADDIA1; ea = 32'd0;
      end else if (c == 7) begin
        ec = C_DONE;   ea = 32'd0;
      end else begin
        ec = C_IDLE;   ea = 32'd0;
      end
      chk($sformatf("t5.c%0d.ctl", c), {24'd0, ctl3}, {24'd0, ec});
      chk($sformatf("t5.c%0d.add", c), if3.AddImmediate, ea);
    end

    // Test 6: random opcode stream on the HOLD_CYCLES=1 instance
    for (int i = 0; i < 200; i++) begin
      if1.start  = ($urandom_range(0, 2) == 0);
      if1.opcode = 2'($urandom_range(0, 3));
      if1.imm    = $urandom;
      if (if1.start && !if1.busy) accepted++;
      tick();
      if (if1.done) dones++;
      chk("t6.excl", $countones({if1.RAout, if1.RBout, if1.RZout}) <= 1, 32'd1);
      chk("t6.inout", {31'd0, (if1.RAin & if1.RAout) | (if1.RBin & if1.RBout) | (if1.RZin & if1.RZout)}, 32'd0);
      if (!if1.busy || if1.done) chk("t6.quiet", {26'd0, ctl1[5:0]}, 32'd0);
    end
    if1.start = 1'b0;
    guard = 0;
    while (if1.busy && guard < 10) begin
      tick();
      if (if1.done) dones++;
      guard++;
    end
    chk("t6.drain", {31'd0, if1.busy}, 32'd0);
    chk("t6.count", dones, accepted);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
